// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the serial program loader that fills the
// PicoBlaze instruction memory from the UART byte stream.
package prog_loader_pkg;

  localparam logic [7:0] SYNC_DEFAULT = 8'h55;
  localparam int         BYTE_W       = 8;
  localparam int         INSTR_W      = 18;
  localparam int         LEN_W        = 10;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEN_HI = 3'd1,
    ST_LEN_LO = 3'd2,
    ST_B0     = 3'd3,
    ST_B1     = 3'd4,
    ST_B2     = 3'd5,
    ST_CSUM   = 3'd6
  } state_e;

  // B0 contributes only its two low bits; the upper six are don't-care.
  function automatic logic [INSTR_W-1:0] pack_instr(input logic [1:0]        b0,
                                                    input logic [BYTE_W-1:0] b1,
                                                    input logic [BYTE_W-1:0] b2);
    return {b0, b1, b2};
  endfunction

endpackage

// File: rtl/loader_timeout.sv
// Inter-byte watchdog: a loadable down-counter that flags when a frame has
// gone CYCLES clocks without a byte.
module loader_timeout #(
  parameter int CYCLES = 1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic en,
  output logic expired
);

  localparam int CNT_W = $clog2(CYCLES + 1);
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(CYCLES);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = LOAD_VAL;
    end else if (en && (count_q != '0)) begin
      count_d = count_q - ONE;
    end
  end

  // Fires on the last counted cycle so the abort lands exactly CYCLES after the load.
  assign expired = en && !load && (count_q == ONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Frame parser, 3-byte instruction packer and checksum for loading the
// instruction memory over the UART while the processor is held in reset.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE      = SYNC_DEFAULT,
  parameter int         TIMEOUT_CYCLES = 1000000,
  parameter int         ADDR_W         = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [BYTE_W-1:0]  rx_data,
  input  logic               rx_valid,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [INSTR_W-1:0] mem_wdata,
  output logic               mem_we,
  output logic               cpu_reset,
  output logic               busy,
  output logic               load_done,
  output logic               load_error
);

  // rx_valid is a one-cycle strobe with no back-pressure: every strobe is
  // consumed in the cycle it appears, so bytes may arrive on every clock.

  state_e             state_q, state_d;
  logic [BYTE_W-1:0]  csum_q, csum_d;
  logic [LEN_W-1:0]   remain_q, remain_d;
  logic [1:0]         len_hi_q, len_hi_d;
  logic [1:0]         b0_q, b0_d;
  logic [BYTE_W-1:0]  b1_q, b1_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [INSTR_W-1:0] wdata_q, wdata_d;
  logic               we_q, we_d;
  logic               cpu_reset_q, cpu_reset_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  logic [BYTE_W-1:0]  sum_next;
  logic               tmo_load;
  logic               tmo_en;
  logic               tmo_expired;

  assign tmo_load = (state_q == ST_IDLE) || rx_valid;
  assign tmo_en   = (state_q != ST_IDLE);
  assign sum_next = csum_q + rx_data;

  loader_timeout #(
    .CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .load    (tmo_load),
    .en      (tmo_en),
    .expired (tmo_expired)
  );

  always_comb begin
    state_d     = state_q;
    csum_d      = csum_q;
    remain_d    = remain_q;
    len_hi_d    = len_hi_q;
    b0_d        = b0_q;
    b1_d        = b1_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    we_d        = 1'b0;
    cpu_reset_d = cpu_reset_q;
    done_d      = done_q;
    err_d       = err_q;

    // Post-increment after each write; the final 1023 -> 0 wrap is harmless.
    if (we_q) begin
      addr_d = addr_q + ADDR_W'(1);
    end

    if (state_q == ST_IDLE) begin
      if (rx_valid && (rx_data == SYNC_BYTE)) begin
        state_d     = ST_LEN_HI;
        cpu_reset_d = 1'b1;
        done_d      = 1'b0;
        err_d       = 1'b0;
        csum_d      = '0;
        addr_d      = '0;
      end
    end else if (tmo_expired) begin
      state_d = ST_IDLE;
      err_d   = 1'b1;
    end else if (rx_valid) begin
      csum_d = sum_next;
      case (state_q)
        ST_LEN_HI: begin
          if (rx_data[7:2] != 6'd0) begin
            state_d = ST_IDLE;
            err_d   = 1'b1;
          end else begin
            len_hi_d = rx_data[1:0];
            state_d  = ST_LEN_LO;
          end
        end
        ST_LEN_LO: begin
          remain_d = {len_hi_q, rx_data};
          state_d  = ST_B0;
        end
        ST_B0: begin
          b0_d    = rx_data[1:0];
          state_d = ST_B1;
        end
        ST_B1: begin
          b1_d    = rx_data;
          state_d = ST_B2;
        end
        ST_B2: begin
          wdata_d = pack_instr(b0_q, b1_q, rx_data);
          we_d    = 1'b1;
          if (remain_q == '0) begin
            state_d = ST_CSUM;
          end else begin
            remain_d = remain_q - LEN_W'(1);
            state_d  = ST_B0;
          end
        end
        ST_CSUM: begin
          state_d = ST_IDLE;
          if (sum_next == '0) begin
            done_d      = 1'b1;
            cpu_reset_d = 1'b0;
          end else begin
            err_d = 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    busy_d = (state_d != ST_IDLE);
  end

  // Reset also drops any write strobe queued by a byte accepted this cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      csum_q      <= '0;
      remain_q    <= '0;
      len_hi_q    <= '0;
      b0_q        <= '0;
      b1_q        <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      cpu_reset_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      csum_q      <= csum_d;
      remain_q    <= remain_d;
      len_hi_q    <= len_hi_d;
      b0_q        <= b0_d;
      b1_q        <= b1_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      we_q        <= we_d;
      cpu_reset_q <= cpu_reset_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign mem_we     = we_q;
  assign cpu_reset  = cpu_reset_q;
  assign busy       = busy_q;
  assign load_done  = done_q;
  assign load_error = err_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: frames are driven byte by byte and every
// memory write is captured and compared against hand-computed expectations.
module tb_prog_loader;

  localparam int ADDR_W = 10;
  localparam int TMO    = 100;

  logic              clk = 1'b0;
  logic              reset;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic [ADDR_W-1:0] mem_addr;
  logic [17:0]       mem_wdata;
  logic              mem_we;
  logic              cpu_reset;
  logic              busy;
  logic              load_done;
  logic              load_error;

  int total = 0;
  int bad   = 0;

  logic [27:0] exp_q[$];
  logic [27:0] got_q[$];

  prog_loader #(
    .SYNC_BYTE      (8'h55),
    .TIMEOUT_CYCLES (TMO),
    .ADDR_W         (ADDR_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .cpu_reset  (cpu_reset),
    .busy       (busy),
    .load_done  (load_done),
    .load_error (load_error)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Write monitor: one entry per cycle that mem_we is high.
  always @(negedge clk) begin
    if (mem_we === 1'b1) got_q.push_back({mem_addr, mem_wdata});
  end

  // ---------------- driver tasks ----------------
  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    idle_cycles(3);
    reset = 1'b0;
    idle_cycles(1);
  endtask

  task automatic drive_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
    @(posedge clk); #1;
    total++;
    if ({mem_addr, mem_wdata, mem_we, cpu_reset, busy, load_done, load_error} !== 33'd0) begin
      bad++;
      $display("FAIL reset_outputs got addr=%h wdata=%h we=%b cpu_rst=%b busy=%b done=%b err=%b required all 0",
               mem_addr, mem_wdata, mem_we, cpu_reset, busy, load_done, load_error);
    end
    idle_cycles(2);
    reset = 1'b0;
    idle_cycles(1);
  endtask

  task automatic test_single();
    got_q.delete(); exp_q.delete();
    exp_q.push_back({10'd0, 18'h3FF0F});
    drive_byte(8'h55);
    total++;
    if (cpu_reset !== 1'b1 || busy !== 1'b1) begin
      bad++;
      $display("FAIL t1_after_sync got cpu_rst=%b busy=%b required 1 1", cpu_reset, busy);
    end
    drive_byte(8'h00); drive_byte(8'h00);
    drive_byte(8'h03); drive_byte(8'hFF); drive_byte(8'h0F);
    drive_byte(8'hEF);  // 00+00+03+FF+0F = 11, -11 = EF
    idle_cycles(2);
    total++;
    if (load_done !== 1'b1 || load_error !== 1'b0 || cpu_reset !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL t1_status got done=%b err=%b cpu_rst=%b busy=%b required 1 0 0 0",
               load_done, load_error, cpu_reset, busy);
    end
    total++;
    if (mem_addr !== 10'd1) begin
      bad++;
      $display("FAIL t1_addr_post got %0d required 1", mem_addr);
    end
    total++;
    if (got_q.size() !== exp_q.size()) begin
      bad++;
      $display("FAIL t1_write_count got %0d required %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL t1_write%0d got addr=%0d data=%h required addr=%0d data=%h",
                 i, got_q[i][27:18], got_q[i][17:0], exp_q[i][27:18], exp_q[i][17:0]);
      end
    end
  endtask

  // N=3 frame with every byte on consecutive cycles; csum_delta corrupts the checksum.
  task automatic send_three(input logic [7:0] csum_delta);
    logic [7:0] body[$];
    logic [7:0] sum;
    body = '{8'h00, 8'h02, 8'h01, 8'h23, 8'h45, 8'h02, 8'hAB, 8'hCD, 8'hFC, 8'h00, 8'h11};
    sum = 8'h00;
    foreach (body[i]) sum = sum + body[i];
    drive_byte(8'h55);
    foreach (body[i]) drive_byte(body[i]);
    drive_byte(8'h00 - sum + csum_delta);
    idle_cycles(2);
  endtask

  task automatic test_back_to_back();
    got_q.delete(); exp_q.delete();
    exp_q.push_back({10'd0, 18'h12345});
    exp_q.push_back({10'd1, 18'h2ABCD});
    exp_q.push_back({10'd2, 18'h00011});
    send_three(8'h00);
    total++;
    if (load_done !== 1'b1 || load_error !== 1'b0 || cpu_reset !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL t2_status got done=%b err=%b cpu_rst=%b busy=%b required 1 0 0 0",
               load_done, load_error, cpu_reset, busy);
    end
    total++;
    if (mem_addr !== 10'd3) begin
      bad++;
      $display("FAIL t2_addr_post got %0d required 3", mem_addr);
    end
    total++;
    if (got_q.size() !== exp_q.size()) begin
      bad++;
      $display("FAIL t2_write_count got %0d required %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL t2_write%0d got addr=%0d data=%h required addr=%0d data=%h",
                 i, got_q[i][27:18], got_q[i][17:0], exp_q[i][27:18], exp_q[i][17:0]);
      end
    end
  endtask

  task automatic test_bad_csum();
    got_q.delete(); exp_q.delete();
    exp_q.push_back({10'd0, 18'h12345});
    exp_q.push_back({10'd1, 18'h2ABCD});
    exp_q.push_back({10'd2, 18'h00011});
    send_three(8'h01);
    total++;
    if (load_done !== 1'b0 || load_error !== 1'b1 || cpu_reset !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL t3_status got done=%b err=%b cpu_rst=%b busy=%b required 0 1 1 0",
               load_done, load_error, cpu_reset, busy);
    end
    total++;
    if (got_q.size() !== exp_q.size()) begin
      bad++;
      $display("FAIL t3_write_count got %0d required %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL t3_write%0d got addr=%0d data=%h required addr=%0d data=%h",
                 i, got_q[i][27:18], got_q[i][17:0], exp_q[i][27:18], exp_q[i][17:0]);
      end
    end
  endtask

  task automatic test_timeout();
    int waited;
    got_q.delete(); exp_q.delete();
    exp_q.push_back({10'd0, 18'h10203});
    drive_byte(8'h55);
    total++;
    if (load_error !== 1'b0 || cpu_reset !== 1'b1) begin
      bad++;
      $display("FAIL t4_sync_clears got err=%b cpu_rst=%b required 0 1", load_error, cpu_reset);
    end
    drive_byte(8'h00); drive_byte(8'h01);
    drive_byte(8'h01); drive_byte(8'h02); drive_byte(8'h03);
    drive_byte(8'h04); drive_byte(8'h05);
    idle_cycles(TMO - 10);
    total++;
    if (busy !== 1'b1 || load_error !== 1'b0) begin
      bad++;
      $display("FAIL t4_before_timeout got busy=%b err=%b required 1 0", busy, load_error);
    end
    waited = 0;
    while (busy !== 1'b0 && waited < 40) begin
      idle_cycles(1);
      waited++;
    end
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL t4_timeout_wait got busy=%b after %0d cycles required 0", busy, waited);
    end
    total++;
    if (load_error !== 1'b1 || load_done !== 1'b0 || cpu_reset !== 1'b1) begin
      bad++;
      $display("FAIL t4_status got err=%b done=%b cpu_rst=%b required 1 0 1",
               load_error, load_done, cpu_reset);
    end
    total++;
    if (got_q.size() !== exp_q.size()) begin
      bad++;
      $display("FAIL t4_write_count got %0d required %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL t4_write%0d got addr=%0d data=%h required addr=%0d data=%h",
                 i, got_q[i][27:18], got_q[i][17:0], exp_q[i][27:18], exp_q[i][17:0]);
      end
    end
  endtask

  task automatic test_bad_len();
    got_q.delete(); exp_q.delete();
    drive_byte(8'h55);
    drive_byte(8'h04);
    total++;
    if (load_error !== 1'b1 || busy !== 1'b0 || cpu_reset !== 1'b1 || load_done !== 1'b0) begin
      bad++;
      $display("FAIL t5_status got err=%b busy=%b cpu_rst=%b done=%b required 1 0 1 0",
               load_error, busy, cpu_reset, load_done);
    end
    // Trailing bytes now land in IDLE and must be ignored.
    drive_byte(8'h00); drive_byte(8'h00);
    drive_byte(8'h01); drive_byte(8'h02); drive_byte(8'h03);
    idle_cycles(3);
    total++;
    if (got_q.size() !== 0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL t5_no_writes got writes=%0d busy=%b required 0 0", got_q.size(), busy);
    end
  endtask

  task automatic test_idle_and_reset();
    got_q.delete(); exp_q.delete();
    do_reset();
    drive_byte(8'h12); drive_byte(8'h34);
    idle_cycles(1);
    total++;
    if (busy !== 1'b0 || cpu_reset !== 1'b0 || load_error !== 1'b0) begin
      bad++;
      $display("FAIL t6_idle_ignore got busy=%b cpu_rst=%b err=%b required 0 0 0",
               busy, cpu_reset, load_error);
    end
    exp_q.push_back({10'd0, 18'h10203});
    drive_byte(8'h55); drive_byte(8'h00); drive_byte(8'h01);
    drive_byte(8'h01); drive_byte(8'h02); drive_byte(8'h03);
    drive_byte(8'h04); drive_byte(8'h05);
    total++;
    if (busy !== 1'b1 || cpu_reset !== 1'b1 || mem_addr !== 10'd1) begin
      bad++;
      $display("FAIL t6_mid_frame got busy=%b cpu_rst=%b addr=%0d required 1 1 1",
               busy, cpu_reset, mem_addr);
    end
    // Final B2 arrives in the same cycle as reset: its write must never appear.
    rx_data  = 8'h06;
    rx_valid = 1'b1;
    reset    = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    reset    = 1'b0;
    total++;
    if ({mem_addr, mem_wdata, mem_we, cpu_reset, busy, load_done, load_error} !== 33'd0) begin
      bad++;
      $display("FAIL t6_after_reset got addr=%h wdata=%h we=%b cpu_rst=%b busy=%b done=%b err=%b required all 0",
               mem_addr, mem_wdata, mem_we, cpu_reset, busy, load_done, load_error);
    end
    idle_cycles(4);
    total++;
    if (got_q.size() !== exp_q.size()) begin
      bad++;
      $display("FAIL t6_write_count got %0d required %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL t6_write%0d got addr=%0d data=%h required addr=%0d data=%h",
                 i, got_q[i][27:18], got_q[i][17:0], exp_q[i][27:18], exp_q[i][17:0]);
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    @(posedge clk); #1;
    test_reset();
    test_single();
    test_back_to_back();
    test_bad_csum();
    test_timeout();
    test_bad_len();
    test_idle_and_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
